tl_rx_write_handler_rcv_tracker: RTL and testbench

Receive-side tracker that sits directly upstream of the write handler's malformed-TLP check. It captures DW0 of each incoming TLP from the data-link-layer beat stream and decodes the type, Length, TC, Attr and AT fields. It counts the payload DWs actually received and, one cycle after each TLP ends, presents a registered result set with a single-cycle `o_malformed_en` strobe for the combinational malformed checker.

---
 rtl/tl_rx_pkg.sv | 40 ++++
 rtl/tl_rx_write_handler_rcv_tracker_if.sv | 39 +++
 rtl/tl_rx_hdr_decode.sv | 48 ++++
 rtl/tl_rx_write_handler_rcv_tracker.sv | 174 +++++++++++++++++
 tb/tb_tl_rx_write_handler_rcv_tracker.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/tl_rx_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// tl_rx_pkg: shared TLP type codes, DW0 field positions, FSM states. Rev 1.0
// ------------------------------------------------------------------------
package tl_rx_pkg;

   localparam int LEN_W = 10;
   localparam int CNT_W = LEN_W + 1;

   localparam logic [2:0] TYP_MEMORY  = 3'b000;
   localparam logic [2:0] TYP_IO      = 3'b001;
   localparam logic [2:0] TYP_CPL     = 3'b010;
   localparam logic [2:0] TYP_CFG     = 3'b011;
   localparam logic [2:0] TYP_MSG     = 3'b100;
   localparam logic [2:0] TYP_INVALID = 3'b111;

   localparam int FMT_HI  = 31;
   localparam int FMT_LO  = 29;
   localparam int TYPE_HI = 28;
   localparam int TYPE_LO = 24;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RX   = 1'b1
   } state_t;

   typedef struct packed {
      logic [2:0]       typ;
      logic [LEN_W-1:0] length;
      logic [2:0]       tc;
      logic [1:0]       attr;
      logic [1:0]       at;
      logic [2:0]       last_byte;
      logic [2:0]       last_rcv;
      logic             eop;
      logic             rcv_done;
   } rpt_t;

endpackage
`default_nettype wire

// File: rtl/tl_rx_write_handler_rcv_tracker_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// tl_rx_write_handler_rcv_tracker_if: beat stream in, result set out. Rev 1.0
// ------------------------------------------------------------------------
interface tl_rx_write_handler_rcv_tracker_if #(
   parameter int DATA_WIDTH = 10,
   parameter int BEAT_DW    = 8
);
   logic                    i_valid;
   logic                    i_sop;
   logic                    i_eop;
   logic [32*BEAT_DW-1:0]   i_data;
   logic [3:0]              i_dw_cnt;

   logic [2:0]              o_typ;
   logic [DATA_WIDTH-1:0]   o_length;
   logic [2:0]              o_tc;
   logic [1:0]              o_attr;
   logic [1:0]              o_at;
   logic [2:0]              o_last_byte;
   logic [2:0]              o_last_rcv_data;
   logic                    o_eop;
   logic                    o_rcv_done;
   logic                    o_malformed_en;
   logic                    o_busy;

   modport slave (
      input  i_valid, i_sop, i_eop, i_data, i_dw_cnt,
      output o_typ, o_length, o_tc, o_attr, o_at, o_last_byte,
             o_last_rcv_data, o_eop, o_rcv_done, o_malformed_en, o_busy
   );

   modport master (
      output i_valid, i_sop, i_eop, i_data, i_dw_cnt,
      input  o_typ, o_length, o_tc, o_attr, o_at, o_last_byte,
             o_last_rcv_data, o_eop, o_rcv_done, o_malformed_en, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/tl_rx_hdr_decode.sv
`default_nettype none
// ------------------------------------------------------------------------
// tl_rx_hdr_decode: combinational TLP DW0 field decoder. Rev 1.0
// ------------------------------------------------------------------------
module tl_rx_hdr_decode
   import tl_rx_pkg::*;
(
   input  logic [31:0]      i_dw0,
   output logic [2:0]       o_typ,
   output logic [2:0]       o_hdr_dw,
   output logic [CNT_W-1:0] o_exp_dw,
   output logic [LEN_W-1:0] o_length,
   output logic [2:0]       o_tc,
   output logic [1:0]       o_attr,
   output logic [1:0]       o_at
);
   logic [2:0] fmt;
   logic [4:0] typ_f;
   logic       unused_bits;

   assign fmt         = i_dw0[FMT_HI:FMT_LO];
   assign typ_f       = i_dw0[TYPE_HI:TYPE_LO];
   assign o_tc        = i_dw0[22:20];
   assign o_attr      = i_dw0[13:12];
   assign o_at        = i_dw0[11:10];
   assign o_length    = i_dw0[LEN_W-1:0];
   assign unused_bits = ^{fmt[2], i_dw0[23], i_dw0[19:14]};

   always_comb begin
      o_typ    = TYP_INVALID;
      o_hdr_dw = fmt[0] ? 3'd4 : 3'd3;
      o_exp_dw = '0;
      casez (typ_f)
         5'b0000?: o_typ = TYP_MEMORY;
         5'b00010: o_typ = TYP_IO;
         5'b0010?: o_typ = TYP_CFG;
         5'b0101?: o_typ = TYP_CPL;
         5'b10???: o_typ = TYP_MSG;
         default:  o_typ = TYP_INVALID;
      endcase
      // Length of zero encodes the maximum payload of 1024 DWs
      if (fmt[1]) begin
         o_exp_dw = (o_length == '0) ? CNT_W'(1024) : {1'b0, o_length};
      end
   end

endmodule
`default_nettype wire

// File: rtl/tl_rx_write_handler_rcv_tracker.sv
`default_nettype none
// ------------------------------------------------------------------------
// tl_rx_write_handler_rcv_tracker: per-TLP payload count and result strobe. Rev 1.0
// ------------------------------------------------------------------------
module tl_rx_write_handler_rcv_tracker
   import tl_rx_pkg::*;
#(
   parameter int DATA_WIDTH = LEN_W,
   parameter int BEAT_DW    = 8
) (
   input  logic clk,
   input  logic arst,
   tl_rx_write_handler_rcv_tracker_if.slave bus
);
   state_t           state_q, state_d;
   rpt_t             hdr_q, hdr_d, rpt_q, rpt_d, pend_q, pend_d;
   rpt_t             new1, new2, single_rpt;
   logic             new1_v, new2_v;
   logic             strobe_q, strobe_d, pend_v_q, pend_v_d;
   logic [CNT_W-1:0] exp_q, exp_d, cnt_q, cnt_d;

   logic [2:0]       dec_typ, dec_hdr_dw, dec_tc, lb_w, lr_w;
   logic [1:0]       dec_attr, dec_at;
   logic [CNT_W-1:0] dec_exp_dw, first_cnt, acc_cnt;
   logic [LEN_W-1:0] dec_length;
   logic [CNT_W:0]   sum_w;
   logic [3:0]       hdr4;
   logic             unused_data;

   tl_rx_hdr_decode u_hdr_decode (
      .i_dw0    (bus.i_data[31:0]),
      .o_typ    (dec_typ),
      .o_hdr_dw (dec_hdr_dw),
      .o_exp_dw (dec_exp_dw),
      .o_length (dec_length),
      .o_tc     (dec_tc),
      .o_attr   (dec_attr),
      .o_at     (dec_at)
   );

   assign unused_data = ^bus.i_data[32*BEAT_DW-1:32];

   always_comb begin
      hdr4      = {1'b0, dec_hdr_dw};
      first_cnt = (bus.i_dw_cnt > hdr4) ? CNT_W'(bus.i_dw_cnt - hdr4) : '0;
      sum_w     = {1'b0, cnt_q} + {{(CNT_W-3){1'b0}}, bus.i_dw_cnt};
      acc_cnt   = sum_w[CNT_W] ? '1 : sum_w[CNT_W-1:0];
      lb_w      = dec_hdr_dw + dec_exp_dw[2:0] - 3'd1;
      lr_w      = bus.i_dw_cnt[2:0] - 3'd1;

      single_rpt           = '0;
      single_rpt.typ       = dec_typ;
      single_rpt.length    = dec_length;
      single_rpt.tc        = dec_tc;
      single_rpt.attr      = dec_attr;
      single_rpt.at        = dec_at;
      single_rpt.last_byte = lb_w;
      single_rpt.last_rcv  = lr_w;
      single_rpt.eop       = 1'b1;
      single_rpt.rcv_done  = (first_cnt == dec_exp_dw);
   end

   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      exp_d   = exp_q;
      cnt_d   = cnt_q;
      new1    = '0;
      new1_v  = 1'b0;
      new2    = '0;
      new2_v  = 1'b0;

      if (bus.i_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.i_sop) begin
                  if (bus.i_eop) begin
                     new1   = single_rpt;
                     new1_v = 1'b1;
                  end else begin
                     hdr_d   = single_rpt;
                     exp_d   = dec_exp_dw;
                     cnt_d   = first_cnt;
                     state_d = ST_RX;
                  end
               end
            end
            ST_RX: begin
               if (bus.i_sop) begin
                  // Abort report goes first; a single-beat successor queues behind it
                  new1          = hdr_q;
                  new1.last_rcv = 3'd0;
                  new1.eop      = 1'b0;
                  new1.rcv_done = (cnt_q == exp_q);
                  new1_v        = 1'b1;
                  if (bus.i_eop) begin
                     new2    = single_rpt;
                     new2_v  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     hdr_d = single_rpt;
                     exp_d = dec_exp_dw;
                     cnt_d = first_cnt;
                  end
               end else begin
                  cnt_d = acc_cnt;
                  if (bus.i_eop) begin
                     new1          = hdr_q;
                     new1.last_rcv = lr_w;
                     new1.eop      = 1'b1;
                     new1.rcv_done = (acc_cnt == exp_q);
                     new1_v        = 1'b1;
                     state_d       = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      rpt_d    = rpt_q;
      strobe_d = 1'b0;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      // Pending is only ever full while idle, so at most one new report competes with it
      if (pend_v_q) begin
         rpt_d    = pend_q;
         strobe_d = 1'b1;
         pend_d   = new1;
         pend_v_d = new1_v;
      end else if (new1_v) begin
         rpt_d    = new1;
         strobe_d = 1'b1;
         pend_d   = new2;
         pend_v_d = new2_v;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q  <= ST_IDLE;
         hdr_q    <= '0;
         exp_q    <= '0;
         cnt_q    <= '0;
         rpt_q    <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         hdr_q    <= hdr_d;
         exp_q    <= exp_d;
         cnt_q    <= cnt_d;
         rpt_q    <= rpt_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         strobe_q <= strobe_d;
      end
   end

   assign bus.o_typ           = rpt_q.typ;
   assign bus.o_length        = DATA_WIDTH'(rpt_q.length);
   assign bus.o_tc            = rpt_q.tc;
   assign bus.o_attr          = rpt_q.attr;
   assign bus.o_at            = rpt_q.at;
   assign bus.o_last_byte     = rpt_q.last_byte;
   assign bus.o_last_rcv_data = rpt_q.last_rcv;
   assign bus.o_eop           = rpt_q.eop;
   assign bus.o_rcv_done      = rpt_q.rcv_done;
   assign bus.o_malformed_en  = strobe_q;
   assign bus.o_busy          = (state_q == ST_RX);

endmodule
`default_nettype wire

// File: tb/tb_tl_rx_write_handler_rcv_tracker.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_tl_rx_write_handler_rcv_tracker: directed scoreboard bench. Rev 1.0
// ------------------------------------------------------------------------
module tb_tl_rx_write_handler_rcv_tracker;
   import tl_rx_pkg::*;

   logic clk = 1'b0;
   logic arst;
   always #5 clk = ~clk;

   tl_rx_write_handler_rcv_tracker_if #(.DATA_WIDTH(10), .BEAT_DW(8)) bus ();

   tl_rx_write_handler_rcv_tracker #(.DATA_WIDTH(10), .BEAT_DW(8)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   rpt_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   logic zero_req = 1'b0;
   logic busy_req = 1'b0;
   logic busy_exp = 1'b0;
   logic end_req  = 1'b0;

   function automatic rpt_t mk(input logic [2:0] typ, input logic [9:0] len,
                               input logic [2:0] tc, input logic [1:0] attr,
                               input logic [1:0] at, input logic [2:0] lb,
                               input logic [2:0] lr, input logic eop,
                               input logic done);
      rpt_t r;
      r.typ = typ; r.length = len; r.tc = tc; r.attr = attr; r.at = at;
      r.last_byte = lb; r.last_rcv = lr; r.eop = eop; r.rcv_done = done;
      return r;
   endfunction

   // Monitor: sole owner of the check counters
   always @(negedge clk) begin
      rpt_t got, e;
      got.typ = bus.o_typ; got.length = bus.o_length; got.tc = bus.o_tc;
      got.attr = bus.o_attr; got.at = bus.o_at; got.last_byte = bus.o_last_byte;
      got.last_rcv = bus.o_last_rcv_data; got.eop = bus.o_eop;
      got.rcv_done = bus.o_rcv_done;
      if (zero_req) begin
         checks++;
         if (got !== '0 || bus.o_malformed_en !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%h strobe=%b busy=%b required all zero",
                     got, bus.o_malformed_en, bus.o_busy);
         end
      end
      if (busy_req) begin
         checks++;
         if (bus.o_busy !== busy_exp) begin
            errors++;
            $display("FAIL busy got=%b required=%b", bus.o_busy, busy_exp);
         end
      end
      if (end_req) begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_reports got=0 required=%0d more reports", exp_q.size());
         end
      end
      if (bus.o_malformed_en === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_report got=%h required=no strobe", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL report got typ=%0d len=%0d tc=%0d attr=%0d at=%0d lb=%0d lr=%0d eop=%0d done=%0d required typ=%0d len=%0d tc=%0d attr=%0d at=%0d lb=%0d lr=%0d eop=%0d done=%0d",
                        got.typ, got.length, got.tc, got.attr, got.at, got.last_byte,
                        got.last_rcv, got.eop, got.rcv_done, e.typ, e.length, e.tc,
                        e.attr, e.at, e.last_byte, e.last_rcv, e.eop, e.rcv_done);
            end
         end
      end
   end

   task automatic beat(input logic sop, input logic eop, input logic [31:0] dw0,
                       input logic [3:0] cnt);
      bus.i_valid  = 1'b1;
      bus.i_sop    = sop;
      bus.i_eop    = eop;
      bus.i_data   = {8{32'hC3A5_5A3C}};
      bus.i_data[31:0] = dw0;
      bus.i_dw_cnt = cnt;
      @(posedge clk);
      #1;
      bus.i_valid  = 1'b0;
      bus.i_sop    = 1'b0;
      bus.i_eop    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic req_zero();
      zero_req = 1'b1;
      @(negedge clk);
      #1;
      zero_req = 1'b0;
   endtask

   task automatic req_busy(input logic v);
      busy_exp = v;
      busy_req = 1'b1;
      @(negedge clk);
      #1;
      busy_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      arst         = 1'b1;
      bus.i_valid  = 1'b0;
      bus.i_sop    = 1'b0;
      bus.i_eop    = 1'b0;
      bus.i_data   = '0;
      bus.i_dw_cnt = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      req_zero();
      arst = 1'b0;
      idle(2);

      // Single-beat MWr, 3DW header, Length 5
      exp_q.push_back(mk(TYP_MEMORY, 10'd5, 3'd0, 2'd0, 2'd0, 3'd7, 3'd7, 1'b1, 1'b1));
      beat(1'b1, 1'b1, 32'h4000_0005, 4'd8);
      idle(1);

      // 4DW MWr Length 16 over 8/8/4 with gaps
      exp_q.push_back(mk(TYP_MEMORY, 10'd16, 3'd0, 2'd0, 2'd0, 3'd3, 3'd3, 1'b1, 1'b1));
      beat(1'b1, 1'b0, 32'h6000_0010, 4'd8);
      idle(1);
      beat(1'b0, 1'b0, 32'h1234_5678, 4'd8);
      idle(2);
      beat(1'b0, 1'b1, 32'h1234_5678, 4'd4);

      // Back-to-back: same header, short by 4 DWs
      exp_q.push_back(mk(TYP_MEMORY, 10'd16, 3'd0, 2'd0, 2'd0, 3'd3, 3'd7, 1'b1, 1'b0));
      beat(1'b1, 1'b0, 32'h6000_0010, 4'd8);
      req_busy(1'b1);
      beat(1'b0, 1'b1, 32'h1234_5678, 4'd8);
      idle(1);

      // Abort of A (TC5 Attr2 AT1) by single-beat CfgWr0 B
      exp_q.push_back(mk(TYP_MEMORY, 10'd16, 3'd5, 2'd2, 2'd1, 3'd3, 3'd0, 1'b0, 1'b0));
      exp_q.push_back(mk(TYP_CFG, 10'd1, 3'd0, 2'd0, 2'd0, 3'd3, 3'd3, 1'b1, 1'b1));
      beat(1'b1, 1'b0, 32'h6050_2410, 4'd8);
      beat(1'b0, 1'b0, 32'h1234_5678, 4'd8);
      beat(1'b1, 1'b1, 32'h4400_0001, 4'd4);
      idle(3);

      // Invalid type, message, completion: single-beat
      exp_q.push_back(mk(TYP_INVALID, 10'd0, 3'd0, 2'd0, 2'd0, 3'd2, 3'd2, 1'b1, 1'b1));
      beat(1'b1, 1'b1, 32'h1B00_0000, 4'd3);
      exp_q.push_back(mk(TYP_MSG, 10'd0, 3'd0, 2'd0, 2'd0, 3'd3, 3'd3, 1'b1, 1'b1));
      beat(1'b1, 1'b1, 32'h3000_0000, 4'd4);
      exp_q.push_back(mk(TYP_CPL, 10'd2, 3'd0, 2'd0, 2'd0, 3'd4, 3'd4, 1'b1, 1'b1));
      beat(1'b1, 1'b1, 32'h4A00_0002, 4'd5);
      idle(1);

      // First beat shorter than the header: contribution saturates at 0
      exp_q.push_back(mk(TYP_MEMORY, 10'd1, 3'd0, 2'd0, 2'd0, 3'd4, 3'd0, 1'b1, 1'b1));
      beat(1'b1, 1'b0, 32'h6000_0001, 4'd2);
      beat(1'b0, 1'b1, 32'h1234_5678, 4'd1);
      idle(1);

      // Length 0 => 1024 DWs, 129 beats, 1027 DWs total
      exp_q.push_back(mk(TYP_MEMORY, 10'd0, 3'd0, 2'd0, 2'd0, 3'd2, 3'd2, 1'b1, 1'b1));
      beat(1'b1, 1'b0, 32'h4000_0000, 4'd8);
      for (int i = 0; i < 127; i++) beat(1'b0, 1'b0, 32'h1234_5678, 4'd8);
      beat(1'b0, 1'b1, 32'h1234_5678, 4'd3);
      idle(2);

      // Reset during RX discards the TLP; orphan eop is dropped
      beat(1'b1, 1'b0, 32'h6000_0010, 4'd8);
      arst = 1'b1;
      req_zero();
      arst = 1'b0;
      beat(1'b0, 1'b1, 32'h1234_5678, 4'd4);
      idle(2);
      exp_q.push_back(mk(TYP_IO, 10'd1, 3'd0, 2'd0, 2'd0, 3'd3, 3'd3, 1'b1, 1'b1));
      beat(1'b1, 1'b1, 32'h4200_0001, 4'd4);
      idle(4);

      end_req = 1'b1;
      @(negedge clk);
      #1;
      end_req = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
